tinyalu_param: RTL and testbench
================================

# tinyalu_param

Parametrised next-generation TinyALU datapath. Operand width and multiplier latency are parameters, and subtract joins the op set. Operands are captured at start. A busy flag blocks overlapping multi-cycle operations, and a one-cycle done pulse marks each result. The block sits between the stimulus driver (A/B/op/start) and the result monitor, in the same position as the fixed 8-bit ALU it supersedes.

## Interface
- WIDTH, 8: operand width in bits; legal 2..32.
- MULT_STAGES, 3: multiply latency in cycles, from the accepting edge to done; legal 2..8.
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A, sampled only at the accepting edge.
- B  input  WIDTH  operand B, sampled only at the accepting edge.
- op  input  3  0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5 sub, 6/7 reserved.
- start  input  1  request; sampled every edge.
- busy  output  1  a multiply is in flight; start is ignored while busy=1.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  2*WIDTH  last completed result, held until the next done.

## Operation
- Acceptance: at a rising edge with reset_n=1, start=1, busy=0 and op in 1..5, the block latches A, B and op.
  - start with op=0, 6 or 7 is ignored: no done, no state change.
- Arithmetic: both operands are zero-extended to 2*WIDTH bits.
  - add: A+B (carry lands in bit WIDTH).
  - and: A&B.
  - xor: A^B.
  - mul: unsigned A*B.
  - sub: (A-B) mod 2^(2*WIDTH). Example: WIDTH=8, 3-5 gives 16'hFFFE.
- FSM states:
  - IDLE: busy=0. An accepted add/and/xor/sub stays in IDLE. An accepted mul goes to MUL.
  - MUL: busy=1. A down-counter is loaded with MULT_STAGES-1 and decrements every edge. When it reaches the end of the count, the FSM returns to IDLE and pulses done with the product.
- result updates only on a done edge. Between dones it holds its value, including across ignored starts.
- done never asserts for two consecutive cycles for the same operation.
- Operand changes after acceptance have no effect on the in-flight result.

## Timing
- Reset: reset_n=0 at an edge gives the following after that edge:
  - state=IDLE, busy=0, done=0, result=0, counter=0, operand latches=0.
  - Reset mid-multiply aborts the operation; no done follows.
- Single-cycle ops: accepted at edge k → done=1 and result valid after edge k, i.e. a latency of 1. With start held high, back-to-back acceptance every cycle gives a done every cycle.
- mul: accepted at edge k → busy=1 after edges k..k+MULT_STAGES-1. done=1 with busy=0 after edge k+MULT_STAGES.
- Start during the done cycle of a mul is accepted (busy=0 then), so a pipelined issue rate of one mul per MULT_STAGES cycles is possible.
- A start that arrives while busy=1 is dropped, not queued. The driver must hold or re-issue it.
- If reset_n=0 and start=1 arrive together, reset wins.

## Structure
- Package tinyalu_param_pkg holds:
  - typedef enum logic [2:0] alu_op_e (NO_OP, ADD, AND, XOR, MUL, SUB).
  - FSM state enum (IDLE, MUL).
  - helper function is_legal_op.
- Sub-module tinyalu_mult_pipe (parameters WIDTH, MULT_STAGES) is the multiply path:
  - a shift register of the product plus a valid bit, with synchronous active-low reset.
  - The top-level FSM, single-cycle ops and the output mux live in tinyalu_param.

## Test plan
- Reset with WIDTH=8: hold reset_n=0 for 2 edges with start=1, op=ADD → busy=0, done=0, result=16'h0000 throughout.
- Single-cycle ops, WIDTH=8: A=8'hFF, B=8'h01.
  - add → 16'h0100 with done after 1 cycle.
  - and → 16'h0001.
  - xor → 16'h00FE.
  - sub with A=3, B=5 → 16'hFFFE.
  - Back-to-back, one done per cycle.
- Multiply with MULT_STAGES=3: A=8'hFF, B=8'hFF → busy high 3 cycles, then done pulse with result 16'hFE01.
  - A second mul start asserted while busy is ignored: exactly one done.
  - A start in the done cycle is accepted.
- Wide config with WIDTH=16, MULT_STAGES=5: 16'hFFFF*16'h0002 → 32'h0001_FFFE after exactly 5 cycles.
- Ignored starts: op=0 or 6 with start=1 → no done, result unchanged from the previous value.
- Mid-op reset: reset_n=0 two cycles into a mul → busy=0 and result=0 next cycle, and no done in any later cycle.

Source files
------------

// File: rtl/tinyalu_param_pkg.sv
// Shared types for the parametrised TinyALU: opcode and FSM state encodings
// plus the opcode legality helper used at acceptance.
package tinyalu_param_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4,
    SUB   = 3'd5
  } alu_op_e;

  // State names are prefixed so they do not collide with the MUL opcode.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

endpackage

// File: rtl/tinyalu_param_if.sv
// Driver/monitor bundle of the TinyALU: operands, opcode and start in,
// busy/done/result out.
interface tinyalu_param_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (output A, B, op, start, input busy, done, result);
  modport slave  (input A, B, op, start, output busy, done, result);
endinterface

// File: rtl/tinyalu_mult_pipe.sv
// Multiply path: the product is formed in the first stage, then shifted down
// MULT_STAGES-2 further registers alongside a valid bit.
module tinyalu_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int N = MULT_STAGES - 1;

  logic [2*WIDTH-1:0] prod_reg [N];
  logic [N-1:0]       valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            valid_reg[gi] <= 1'b0;
            prod_reg[gi]  <= '0;
          end else begin
            valid_reg[gi] <= in_valid;
            prod_reg[gi]  <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            valid_reg[gi] <= 1'b0;
            prod_reg[gi]  <= '0;
          end else begin
            valid_reg[gi] <= valid_reg[gi-1];
            prod_reg[gi]  <= prod_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid   = valid_reg[N-1];
  assign out_product = prod_reg[N-1];

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised TinyALU: single-cycle add/and/xor/sub, multi-cycle multiply
// through tinyalu_mult_pipe, busy interlock and a one-cycle done pulse.
module tinyalu_param
  import tinyalu_param_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  tinyalu_param_if.slave bus
);

  localparam int CW = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;

  state_e             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  alu_op_e            op_reg;
  logic               done_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic               accept;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] single_res;
  logic               pipe_in_valid;
  logic               pipe_valid;
  logic [2*WIDTH-1:0] pipe_product;

  assign accept = bus.start && (state_reg == ST_IDLE) && is_legal_op(bus.op);

  always_comb begin
    ext_a      = {{WIDTH{1'b0}}, bus.A};
    ext_b      = {{WIDTH{1'b0}}, bus.B};
    single_res = '0;
    case (bus.op)
      ADD:     single_res = ext_a + ext_b;
      AND:     single_res = ext_a & ext_b;
      XOR:     single_res = ext_a ^ ext_b;
      SUB:     single_res = ext_a - ext_b;
      default: single_res = '0;
    endcase
  end

  // The pipe is fed from the latched operands on the first MUL-state edge.
  assign pipe_in_valid = (state_reg == ST_MUL) && (op_reg == MUL) &&
                         (cnt_reg == CW'(MULT_STAGES - 1));

  tinyalu_mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (pipe_in_valid),
    .in_a        (a_reg),
    .in_b        (b_reg),
    .out_valid   (pipe_valid),
    .out_product (pipe_product)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= NO_OP;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_reg  <= bus.A;
            b_reg  <= bus.B;
            op_reg <= alu_op_e'(bus.op);
            if (bus.op == MUL) begin
              state_reg <= ST_MUL;
              cnt_reg   <= CW'(MULT_STAGES - 1);
            end else begin
              result_reg <= single_res;
              done_reg   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (pipe_valid) begin
            state_reg  <= ST_IDLE;
            result_reg <= pipe_product;
            done_reg   <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_reg == ST_MUL);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed bench for tinyalu_param: an 8-bit/3-stage and a 16-bit/5-stage instance.
module tb_tinyalu_param;
  import tinyalu_param_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  tinyalu_param_if #(.WIDTH(8))  bus8 ();
  tinyalu_param_if #(.WIDTH(16)) bus16 ();

  tinyalu_param #(.WIDTH(8), .MULT_STAGES(3)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  tinyalu_param #(.WIDTH(16), .MULT_STAGES(5)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic busy, input logic done, input logic [15:0] res);
    check({name, ".busy"},   32'(bus8.busy),   32'(busy));
    check({name, ".done"},   32'(bus8.done),   32'(done));
    check({name, ".result"}, 32'(bus8.result), 32'(res));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{ADD, 8'hFF, 8'h01, 16'h0100};
    vecs[1] = '{AND, 8'hFF, 8'h01, 16'h0001};
    vecs[2] = '{XOR, 8'hFF, 8'h01, 16'h00FE};
    vecs[3] = '{SUB, 8'h03, 8'h05, 16'hFFFE};
    vecs[4] = '{ADD, 8'hFF, 8'hFF, 16'h01FE};
    vecs[5] = '{SUB, 8'h05, 8'h03, 16'h0002};
    vecs[6] = '{AND, 8'hAA, 8'h0F, 16'h000A};
    vecs[7] = '{XOR, 8'hAA, 8'h55, 16'h00FF};

    // Reset held with a pending start: reset must win.
    reset_n     = 1'b0;
    bus8.start  = 1'b1;
    bus8.op     = ADD;
    bus8.A      = 8'hFF;
    bus8.B      = 8'h01;
    bus16.start = 1'b0;
    bus16.op    = NO_OP;
    bus16.A     = '0;
    bus16.B     = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check8("reset", 1'b0, 1'b0, 16'h0000);
      $display("reset cycle %0d busy=%0b done=%0b result=0x%04h", i, bus8.busy, bus8.done, bus8.result);
    end
    bus8.start = 1'b0;
    reset_n    = 1'b1;
    tick();
    check8("post_reset_idle", 1'b0, 1'b0, 16'h0000);

    // Back-to-back single-cycle ops with start held high.
    bus8.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus8.op = vecs[i].op;
      bus8.A  = vecs[i].a;
      bus8.B  = vecs[i].b;
      tick();
      check8($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].exp);
      $display("vec%0d op=%0d A=0x%02h B=0x%02h result=0x%04h exp=0x%04h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus8.result, vecs[i].exp);
    end

    // Ignored starts: reserved opcodes and no_op leave result alone.
    for (int i = 0; i < 3; i++) begin
      bus8.op = (i == 0) ? 3'd0 : ((i == 1) ? 3'd6 : 3'd7);
      tick();
      check8($sformatf("ignored_op%0d", bus8.op), 1'b0, 1'b0, 16'h00FF);
      $display("ignored op=%0d done=%0b result=0x%04h", bus8.op, bus8.done, bus8.result);
    end

    // Multiply FF*FF; a competing mul start with new operands while busy is dropped.
    bus8.op = MUL;
    bus8.A  = 8'hFF;
    bus8.B  = 8'hFF;
    tick();
    check8("mul_k", 1'b1, 1'b0, 16'h00FF);
    bus8.A = 8'h01;
    bus8.B = 8'h01;
    for (int i = 1; i < 3; i++) begin
      tick();
      check8($sformatf("mul_k+%0d", i), 1'b1, 1'b0, 16'h00FF);
    end
    tick();
    check8("mul_done", 1'b0, 1'b1, 16'hFE01);
    $display("mul FF*FF result=0x%04h done=%0b", bus8.result, bus8.done);

    // Start in the done cycle is accepted: mul 2*3.
    bus8.A = 8'h02;
    bus8.B = 8'h03;
    tick();
    check8("mul2_accept", 1'b1, 1'b0, 16'hFE01);
    bus8.start = 1'b0;
    tick();
    tick();
    check8("mul2_busy", 1'b1, 1'b0, 16'hFE01);
    tick();
    check8("mul2_done", 1'b0, 1'b1, 16'h0006);
    $display("mul 02*03 result=0x%04h done=%0b", bus8.result, bus8.done);
    tick();
    check8("mul2_after", 1'b0, 1'b0, 16'h0006);

    // Mid-multiply reset aborts the operation.
    bus8.start = 1'b1;
    bus8.op    = MUL;
    bus8.A     = 8'h0F;
    bus8.B     = 8'h0F;
    tick();
    bus8.start = 1'b0;
    tick();
    check8("abort_busy", 1'b1, 1'b0, 16'h0006);
    reset_n = 1'b0;
    tick();
    check8("abort_reset", 1'b0, 1'b0, 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check8($sformatf("abort_quiet%0d", i), 1'b0, 1'b0, 16'h0000);
    end
    $display("abort sequence result=0x%04h busy=%0b", bus8.result, bus8.busy);

    // Wide instance: FFFF*0002 with five-cycle latency, then a 16-bit subtract.
    bus16.start = 1'b1;
    bus16.op    = MUL;
    bus16.A     = 16'hFFFF;
    bus16.B     = 16'h0002;
    tick();
    bus16.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check($sformatf("w16_busy%0d", i), 32'(bus16.busy), 32'd1);
      check($sformatf("w16_done%0d", i), 32'(bus16.done), 32'd0);
    end
    tick();
    check("w16_mul_done",   32'(bus16.done), 32'd1);
    check("w16_mul_busy",   32'(bus16.busy), 32'd0);
    check("w16_mul_result", bus16.result,    32'h0001_FFFE);
    $display("w16 mul FFFF*0002 result=0x%08h", bus16.result);

    bus16.start = 1'b1;
    bus16.op    = SUB;
    bus16.A     = 16'h0003;
    bus16.B     = 16'h0005;
    tick();
    bus16.start = 1'b0;
    check("w16_sub_done",   32'(bus16.done), 32'd1);
    check("w16_sub_result", bus16.result,    32'hFFFF_FFFE);
    $display("w16 sub 0003-0005 result=0x%08h", bus16.result);
    tick();
    check("w16_sub_pulse", 32'(bus16.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
